// File: rtl/mod_diff_decoder_if.sv
// Valid/ready stream bundle for the modular difference decoder.
// The input side carries x[n]; the output side carries d[n].
interface mod_diff_decoder_if #(
  parameter int W = 7
);
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         s_first;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_first;

  modport slave (
    input  s_valid, s_data, s_first, m_ready,
    output s_ready, m_valid, m_data, m_first
  );

  modport master (
    output s_valid, s_data, s_first, m_ready,
    input  s_ready, m_valid, m_data, m_first
  );
endinterface

// File: rtl/mod_diff_decoder.sv
// Streaming modular difference decoder: d[n] = (x[n] - x[n-1]) mod M.
// Results are queued in a 2-entry output FIFO that feeds m_data and m_first.
module mod_diff_decoder #(
  parameter int M = 100,
  parameter int W = $clog2(M)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  mod_diff_decoder_if.slave    bus,
  output logic                 err_range,
  output logic [15:0]          smp_cnt
);

  localparam logic [W:0] MW = (W+1)'(M);

  function automatic logic [W-1:0] range_reduce(input logic [W-1:0] x);
    logic [W:0] xe;
    xe = {1'b0, x};
    if (xe >= MW) return W'(xe - MW);
    return x;
  endfunction

  function automatic logic [W-1:0] mod_diff(input logic [W-1:0] x, input logic [W-1:0] p);
    logic [W:0] xe;
    logic [W:0] pe;
    xe = {1'b0, x};
    pe = {1'b0, p};
    if (xe >= pe) return W'(xe - pe);
    return W'(xe + MW - pe);
  endfunction

  logic [W-1:0] r_prev;
  logic [15:0]  r_smp;
  logic         r_err;
  logic [1:0]   r_cnt;
  logic [W-1:0] r_head_d;
  logic         r_head_f;
  logic [W-1:0] r_tail_d;
  logic         r_tail_f;

  logic         w_s_ready;
  logic         w_push;
  logic         w_pop;
  logic         w_oor;
  logic [W-1:0] w_x;
  logic [W-1:0] w_ref;
  logic [W-1:0] w_diff;

  assign w_s_ready = (r_cnt < 2'd2) && !clr;
  assign w_push    = bus.s_valid && w_s_ready;
  assign w_pop     = (r_cnt != 2'd0) && bus.m_ready;
  assign w_oor     = ({1'b0, bus.s_data} >= MW);
  assign w_x       = range_reduce(bus.s_data);
  assign w_ref     = bus.s_first ? '0 : r_prev;
  assign w_diff    = mod_diff(w_x, w_ref);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev   <= '0;
      r_smp    <= '0;
      r_err    <= 1'b0;
      r_cnt    <= 2'd0;
      r_head_d <= '0;
      r_head_f <= 1'b0;
      r_tail_d <= '0;
      r_tail_f <= 1'b0;
    end else if (clr) begin
      // A pop in this cycle is dropped along with the rest of the FIFO.
      r_prev <= '0;
      r_smp  <= '0;
      r_err  <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_push) begin
        r_prev <= w_x;
        r_smp  <= r_smp + 16'd1;
        if (w_oor) r_err <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_head_d <= w_diff;
            r_head_f <= bus.s_first;
          end else begin
            r_tail_d <= w_diff;
            r_tail_f <= bus.s_first;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_head_d <= r_tail_d;
          r_head_f <= r_tail_f;
          r_cnt    <= r_cnt - 2'd1;
        end
        // Push with pop only happens at count 1: the new entry becomes the head.
        2'b11: begin
          r_head_d <= w_diff;
          r_head_f <= bus.s_first;
        end
        default: ;
      endcase
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.m_valid = (r_cnt != 2'd0);
  assign bus.m_data  = r_head_d;
  assign bus.m_first = r_head_f;
  assign err_range   = r_err;
  assign smp_cnt     = r_smp;

endmodule

// File: tb/tb_mod_diff_decoder.sv
// Directed bench for mod_diff_decoder: a reference model fills a scoreboard
// on each input transfer and output transfers are popped and compared.
module tb_mod_diff_decoder;

  typedef struct packed {
    logic [6:0] d;
    logic       f;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        clr_a;
  logic        clr_b;
  logic        err_a;
  logic        err_b;
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;

  mod_diff_decoder_if #(.W(7)) ifa ();
  mod_diff_decoder_if #(.W(4)) ifb ();

  mod_diff_decoder #(.M(100)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_a),
    .bus       (ifa.slave),
    .err_range (err_a),
    .smp_cnt   (cnt_a)
  );

  mod_diff_decoder #(.M(16)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_b),
    .bus       (ifb.slave),
    .err_range (err_b),
    .smp_cnt   (cnt_b)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  int   m_prev = 0;
  bit   acc_a = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_prev = 0;
  endtask

  // Observes DUT A at the falling edge, where handshakes are stable.
  task automatic monitor();
    int   xr;
    int   p;
    exp_t e;
    acc_a = 1'b0;
    if (rst) return;
    if (clr_a) begin
      model_reset();
      return;
    end
    if (ifa.m_valid && ifa.m_ready) begin
      chk("sb_has_entry", 32'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("m_data", 32'(ifa.m_data), 32'(e.d));
        chk("m_first", 32'(ifa.m_first), 32'(e.f));
      end
    end
    if (ifa.s_valid && ifa.s_ready) begin
      acc_a = 1'b1;
      xr = (int'(ifa.s_data) >= 100) ? int'(ifa.s_data) - 100 : int'(ifa.s_data);
      p  = ifa.s_first ? 0 : m_prev;
      e.d = 7'((xr - p + 100) % 100);
      e.f = ifa.s_first;
      sb_q.push_back(e);
      m_prev = xr;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int x, input bit f);
    ifa.s_valid = 1'b1;
    ifa.s_data  = 7'(x);
    ifa.s_first = f;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc_a) break;
    end
    chk("accepted", 32'(acc_a), 1);
    ifa.s_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr_a = 1'b0; clr_b = 1'b0;
    ifa.s_valid = 1'b0; ifa.s_data = '0; ifa.s_first = 1'b0; ifa.m_ready = 1'b0;
    ifb.s_valid = 1'b0; ifb.s_data = '0; ifb.s_first = 1'b0; ifb.m_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_s_ready", 32'(ifa.s_ready), 1);
    chk("rst_m_valid", 32'(ifa.m_valid), 0);
    chk("rst_m_data", 32'(ifa.m_data), 0);
    chk("rst_m_first", 32'(ifa.m_first), 0);
    chk("rst_err", 32'(err_a), 0);
    chk("rst_cnt", 32'(cnt_a), 0);
    tick();

    // Frame decode
    ifa.m_ready = 1'b1;
    send_a(10, 1'b1);
    chk("latency_m_valid", 32'(ifa.m_valid), 1);
    chk("latency_m_data", 32'(ifa.m_data), 10);
    send_a(30, 1'b0);
    send_a(25, 1'b0);
    send_a(99, 1'b0);
    tick();
    tick();
    chk("frame_cnt", 32'(cnt_a), 4);
    chk("frame_drained", 32'(sb_q.size()), 0);
    chk("frame_err", 32'(err_a), 0);

    // Range error
    send_a(40, 1'b1);
    chk("range_err_before", 32'(err_a), 0);
    send_a(120, 1'b0);
    chk("range_err_set", 32'(err_a), 1);
    send_a(20, 1'b0);
    tick();
    tick();
    chk("range_err_sticky", 32'(err_a), 1);
    chk("range_cnt", 32'(cnt_a), 7);
    chk("range_drained", 32'(sb_q.size()), 0);

    // Backpressure
    ifa.m_ready = 1'b0;
    send_a(5, 1'b1);
    send_a(60, 1'b0);
    chk("bp_s_ready_low", 32'(ifa.s_ready), 0);
    chk("bp_m_valid", 32'(ifa.m_valid), 1);
    ifa.s_valid = 1'b1; ifa.s_data = 7'd30; ifa.s_first = 1'b0;
    repeat (3) tick();
    chk("bp_cnt_held", 32'(cnt_a), 9);
    chk("bp_still_blocked", 32'(ifa.s_ready), 0);
    ifa.m_ready = 1'b1;
    tick();
    chk("bp_ready_after_pop", 32'(ifa.s_ready), 1);
    send_a(30, 1'b0);
    send_a(99, 1'b0);
    send_a(0, 1'b0);
    tick();
    tick();
    chk("bp_cnt", 32'(cnt_a), 12);
    chk("bp_drained", 32'(sb_q.size()), 0);

    // Clear mid-stream with a full FIFO
    ifa.m_ready = 1'b0;
    send_a(120, 1'b1);
    send_a(70, 1'b0);
    chk("clr_pre_full", 32'(ifa.s_ready), 0);
    chk("clr_pre_err", 32'(err_a), 1);
    clr_a = 1'b1;
    ifa.s_valid = 1'b1; ifa.s_data = 7'd33; ifa.s_first = 1'b0;
    tick();
    clr_a = 1'b0;
    ifa.s_valid = 1'b0;
    chk("clr_m_valid", 32'(ifa.m_valid), 0);
    chk("clr_cnt", 32'(cnt_a), 0);
    chk("clr_err", 32'(err_a), 0);
    ifa.m_ready = 1'b1;
    send_a(5, 1'b0);
    tick();
    tick();
    chk("clr_post_drained", 32'(sb_q.size()), 0);
    clr_a = 1'b1;
    ifa.s_valid = 1'b1; ifa.s_data = 7'd9;
    #1;
    chk("clr_blocks_ready", 32'(ifa.s_ready), 0);
    tick();
    clr_a = 1'b0;
    ifa.s_valid = 1'b0;
    tick();
    chk("clr_empty_cnt", 32'(cnt_a), 0);
    chk("clr_empty_m_valid", 32'(ifa.m_valid), 0);

    // Asynchronous reset between edges
    ifa.m_ready = 1'b0;
    send_a(44, 1'b1);
    chk("arst_pre_m_valid", 32'(ifa.m_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_m_valid", 32'(ifa.m_valid), 0);
    chk("arst_cnt", 32'(cnt_a), 0);
    chk("arst_s_ready", 32'(ifa.s_ready), 1);
    model_reset();
    tick();
    rst = 1'b0;
    ifa.m_ready = 1'b1;
    send_a(7, 1'b1);
    tick();
    tick();
    chk("arst_post_cnt", 32'(cnt_a), 1);
    chk("arst_drained", 32'(sb_q.size()), 0);

    // Wrap: M = 16 and the 16-bit sample counter
    ifb.m_ready = 1'b1;
    ifb.s_valid = 1'b1; ifb.s_data = 4'd15; ifb.s_first = 1'b1;
    tick();
    chk("wrap_m_valid", 32'(ifb.m_valid), 1);
    chk("wrap_first_data", 32'(ifb.m_data), 15);
    chk("wrap_first_flag", 32'(ifb.m_first), 1);
    ifb.s_data = 4'd3; ifb.s_first = 1'b0;
    tick();
    chk("wrap_diff_data", 32'(ifb.m_data), 4);
    chk("wrap_diff_flag", 32'(ifb.m_first), 0);
    ifb.s_data = 4'd0;
    for (int i = 0; i < 65533; i++) tick();
    chk("wrap_cnt_max", 32'(cnt_b), 65535);
    tick();
    chk("wrap_cnt_zero", 32'(cnt_b), 0);
    chk("wrap_no_err", 32'(err_b), 0);
    ifb.s_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
